moving_sum_decoder: RTL and testbench

- Inverse of the 9-tap moving-sum buffer.
- Receives the stream of windowed sums S[n] = x[n]+x[n-1]+…+x[n-TAPS+1] (mod 2^WIDTH) and reconstructs the original samples x[n] = S[n] − S[n-1] + x[n-TAPS] (mod 2^WIDTH).
- Sits on the receive side of the summed-sample link and restores per-sample data for downstream logic.
- Uses a valid/ready handshake on both sides, with one output register stage.

---
 rtl/moving_sum_decoder.sv | 110 +++++++++++
 tb/tb_moving_sum_decoder.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/moving_sum_decoder.sv
// rtl/moving_sum_decoder.sv - inverse of the TAPS-wide moving-sum encoder, x[n] = S[n] - S[n-1] + x[n-TAPS]
// Optional: define MSD_SAMPLE_COUNT_EN to add the 16-bit output handshake counter sample_cnt.
module moving_sum_decoder #(
    parameter int WIDTH = 12,
    parameter int TAPS  = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic [WIDTH-1:0] in_sum,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
`ifdef MSD_SAMPLE_COUNT_EN
    output logic [15:0]      sample_cnt,
`endif
    output logic             primed
);

    localparam int PTR_W  = (TAPS > 1) ? $clog2(TAPS) : 1;
    localparam int FILL_W = $clog2(TAPS + 1);

    typedef enum logic {ST_FILL, ST_RUN} state_t;

    state_t             r_state, w_state_nxt;
    logic [FILL_W-1:0]  r_fill, w_fill_nxt;
    logic [WIDTH-1:0]   r_hist [TAPS];
    logic [PTR_W-1:0]   r_wptr;
    logic [WIDTH-1:0]   r_prev_sum;
    logic [WIDTH-1:0]   r_out_data;
    logic               r_out_valid;
    logic               w_accept;
    logic [WIDTH-1:0]   w_x;

    assign in_ready  = !clr && (!r_out_valid || out_ready);
    assign w_accept  = in_valid && in_ready;
    // hist[wptr] is the sample leaving the window, so adding it back undoes the subtraction
    assign w_x       = in_sum - r_prev_sum + r_hist[r_wptr];
    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;
    assign primed    = (r_state == ST_RUN);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_FILL;
            r_fill  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_fill  <= w_fill_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_fill_nxt  = r_fill;
        if (clr) begin
            w_state_nxt = ST_FILL;
            w_fill_nxt  = '0;
        end else if (w_accept && r_state == ST_FILL) begin
            if (r_fill == FILL_W'(TAPS - 1)) begin
                w_state_nxt = ST_RUN;
            end else begin
                w_fill_nxt = r_fill + FILL_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < TAPS; i++) r_hist[i] <= '0;
            r_wptr      <= '0;
            r_prev_sum  <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
        end else if (clr) begin
            for (int i = 0; i < TAPS; i++) r_hist[i] <= '0;
            r_wptr      <= '0;
            r_prev_sum  <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
        end else if (w_accept) begin
            r_hist[r_wptr] <= w_x;
            r_prev_sum     <= in_sum;
            r_wptr         <= (r_wptr == PTR_W'(TAPS - 1)) ? '0 : r_wptr + PTR_W'(1);
            r_out_data     <= w_x;
            r_out_valid    <= 1'b1;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

`ifdef MSD_SAMPLE_COUNT_EN
    logic [15:0] r_sample_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sample_cnt <= '0;
        end else if (clr) begin
            r_sample_cnt <= '0;
        end else if (r_out_valid && out_ready) begin
            r_sample_cnt <= r_sample_cnt + 16'd1;
        end
    end

    assign sample_cnt = r_sample_cnt;
`endif

endmodule

// File: tb/tb_moving_sum_decoder.sv
// tb/tb_moving_sum_decoder.sv - randomized and directed check of moving_sum_decoder against an encoder model
module tb_moving_sum_decoder;

    localparam int W    = 12;
    localparam int TAPS = 9;

    logic         clk = 1'b0;
    logic         rst;
    logic         clr;
    logic [W-1:0] in_sum;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] out_data;
    logic         out_valid;
    logic         out_ready;
    logic         primed;
`ifdef MSD_SAMPLE_COUNT_EN
    logic [15:0]  sample_cnt;
`endif

    moving_sum_decoder #(.WIDTH(W), .TAPS(TAPS)) dut (
        .clk        (clk),
        .rst        (rst),
        .clr        (clr),
        .in_sum     (in_sum),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
`ifdef MSD_SAMPLE_COUNT_EN
        .sample_cnt (sample_cnt),
`endif
        .primed     (primed)
    );

    always #5 clk = ~clk;

    int           errors = 0;
    int           checks = 0;
    logic [W-1:0] enc_h [$];
    logic         exp_ov;
    logic [W-1:0] exp_od;
    int           accepts;
    int           stall;
    int           exp_cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Encoder: window sum of the new sample plus the TAPS-1 most recent ones
    function automatic logic [W-1:0] enc_sum(input logic [W-1:0] x);
        logic [W-1:0] s;
        s = x;
        foreach (enc_h[i]) s = s + enc_h[i];
        return s;
    endfunction

    task automatic model_reset();
        enc_h = {};
        repeat (TAPS - 1) enc_h.push_back('0);
        exp_ov  = 1'b0;
        exp_od  = '0;
        accepts = 0;
        exp_cnt = 0;
    endtask

    task automatic cyc(input logic v, input logic [W-1:0] x, input logic ordy, input logic c, output logic acc);
        logic exp_rdy;
        in_valid  = v;
        in_sum    = enc_sum(x);
        out_ready = ordy;
        clr       = c;
        #1;
        exp_rdy = !c && (!exp_ov || ordy);
        chk("in_ready", in_ready, exp_rdy);
        acc = v && exp_rdy;
        @(posedge clk);
        if (c) begin
            model_reset();
        end else begin
            if (exp_ov && ordy) exp_cnt = (exp_cnt + 1) % 65536;
            if (acc) begin
                exp_ov = 1'b1;
                exp_od = x;
                accepts++;
                enc_h.push_back(x);
                void'(enc_h.pop_front());
            end else if (ordy) begin
                exp_ov = 1'b0;
            end
        end
        @(negedge clk);
        chk("out_valid", out_valid, exp_ov);
        chk("out_data", out_data, exp_od);
        chk("primed", primed, accepts >= TAPS);
`ifdef MSD_SAMPLE_COUNT_EN
        chk("sample_cnt", sample_cnt, exp_cnt);
`endif
    endtask

    task automatic send(input logic [W-1:0] x);
        logic acc;
        logic o;
        int   tries;
        acc   = 1'b0;
        tries = 0;
        while (!acc && tries < 20) begin
            if (stall > 0) begin
                stall--;
                o = 1'b0;
            end else begin
                o = 1'b1;
            end
            cyc(1'b1, x, o, 1'b0, acc);
            tries++;
        end
        chk("send_accepted", acc, 1'b1);
    endtask

    task automatic idle(input logic ordy);
        logic acc;
        cyc(1'b0, '0, ordy, 1'b0, acc);
    endtask

    task automatic async_reset();
        in_valid = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_data", out_data, 0);
        chk("rst_primed", primed, 1'b0);
        model_reset();
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        logic acc;
        rst = 1'b0; clr = 1'b0; in_valid = 1'b0; in_sum = '0; out_ready = 1'b1;
        stall = 0;
        model_reset();
        @(negedge clk);
        chk("reset_out_valid", out_valid, 1'b0);
        chk("reset_out_data", out_data, 0);
        chk("reset_primed", primed, 1'b0);
        chk("reset_in_ready", in_ready, 1'b1);
        rst = 1'b1;
        @(negedge clk);

        for (int i = 1; i <= 20; i++) send(W'(i));
        idle(1'b1);

        cyc(1'b1, W'(99), 1'b1, 1'b1, acc);
        chk("clr_no_accept", acc, 1'b0);
        send(W'(7));
        chk("clr_then_sum7", out_data, 7);

        for (int i = 1; i <= 12; i++) begin
            if (i == 6) stall = 3;
            send(W'(i));
        end
        idle(1'b1);

        for (int i = 1; i <= 5; i++) send(W'(i));
        async_reset();
        for (int i = 1; i <= 12; i++) send(W'(i));
        idle(1'b1);

        async_reset();
        for (int i = 0; i < 12; i++) send(W'(4095));
        idle(1'b1);

        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) == 0) idle(1'($urandom_range(0, 1)));
            if ($urandom_range(0, 5) == 0) stall = $urandom_range(1, 3);
            if ($urandom_range(0, 60) == 0) cyc(1'b1, W'($urandom), 1'b1, 1'b1, acc);
            send(W'($urandom));
        end
        idle(1'b1);

        cyc(1'b0, '0, 1'b1, 1'b1, acc);
        chk("final_clr_primed", primed, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
